// File: rtl/tick_scheduler.sv
// tick_scheduler: a bank of per-channel programmable down-counters that produce
// single-cycle tick strobes. One valid/ready configuration port shares the bank.
// A reprogram of a running channel waits in a single pending slot until that
// channel's period boundary, so a period in progress is never cut short.
module tick_scheduler #(
    parameter int CHANNELS = 4,
    parameter int BITS     = 8,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                in_clock,
    input  logic                reset_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_channel,
    input  logic [BITS-1:0]     cfg_divisor,
    input  logic                cfg_enable,
    input  logic                cfg_oneshot,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] active,
    output logic                pending
);

    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] oneshot;
    logic [BITS-1:0]     div [CHANNELS];
    logic [BITS-1:0]     cnt [CHANNELS];

    logic [CW-1:0]       p_channel;
    logic [BITS-1:0]     p_divisor;
    logic                p_oneshot;

    logic                accept;
    logic [CHANNELS-1:0] channel_sel;
    logic [CHANNELS-1:0] direct_hit;
    logic [CHANNELS-1:0] pend_hit;
    logic                defer;

    // A channel ticks whenever it is enabled and its counter has reached zero.
    always_comb begin
        tick   = '0;
        active = en;
        for (int i = 0; i < CHANNELS; i++) begin
            tick[i] = en[i] && (cnt[i] == '0);
        end
    end

    assign cfg_ready = !pending;
    assign accept    = cfg_valid && cfg_ready;

    // Decide whether an accepted request applies now or has to wait for the
    // boundary, and which channel the pending slot lands on this cycle.
    always_comb begin
        channel_sel = '0;
        direct_hit  = '0;
        pend_hit    = '0;
        defer       = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            channel_sel[i] = accept && (cfg_channel == CW'(i));
            if (channel_sel[i]) begin
                if (!en[i] || !cfg_enable || tick[i]) begin
                    direct_hit[i] = 1'b1;
                end else begin
                    defer = 1'b1;
                end
            end
            pend_hit[i] = pending && (p_channel == CW'(i)) && tick[i];
        end
    end

    // Per-channel counters: reload at zero, apply configuration at boundaries,
    // and clear the enable of a oneshot channel after its tick.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            en      <= '0;
            oneshot <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                div[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (direct_hit[i]) begin
                    en[i]      <= cfg_enable;
                    div[i]     <= cfg_divisor;
                    oneshot[i] <= cfg_oneshot;
                    cnt[i]     <= cfg_divisor;
                end else if (pend_hit[i]) begin
                    en[i]      <= 1'b1;
                    div[i]     <= p_divisor;
                    oneshot[i] <= p_oneshot;
                    cnt[i]     <= p_divisor;
                end else if (en[i]) begin
                    if (cnt[i] == '0) begin
                        cnt[i] <= div[i];
                    end else begin
                        cnt[i] <= cnt[i] - BITS'(1);
                    end
                    if (tick[i] && oneshot[i]) begin
                        en[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Single pending slot: filled by a deferred reprogram, emptied when the
    // target channel reaches its boundary. Stops never land here, so the
    // stored request always enables its channel.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= 1'b0;
            p_channel <= '0;
            p_divisor <= '0;
            p_oneshot <= 1'b0;
        end else if (defer) begin
            pending   <= 1'b1;
            p_channel <= cfg_channel;
            p_divisor <= cfg_divisor;
            p_oneshot <= cfg_oneshot;
        end else if (pend_hit != '0) begin
            pending   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed testbench for tick_scheduler: main instance (4 channels, 8 bits)
// plus a narrow instance (3 channels, 4 bits) for wrap and out-of-range cases.
module tb_tick_scheduler;

    logic       in_clock;
    logic       reset_n;

    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_channel;
    logic [7:0] cfg_divisor;
    logic       cfg_enable;
    logic       cfg_oneshot;
    logic [3:0] tick;
    logic [3:0] active;
    logic       pending;

    logic       cfg4_valid;
    logic       cfg4_ready;
    logic [1:0] cfg4_channel;
    logic [3:0] cfg4_divisor;
    logic       cfg4_enable;
    logic       cfg4_oneshot;
    logic [2:0] tick4;
    logic [2:0] active4;
    logic       pending4;

    int errors = 0;
    int checks = 0;

    tick_scheduler #(.CHANNELS(4), .BITS(8)) dut (
        .in_clock   (in_clock),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_channel(cfg_channel),
        .cfg_divisor(cfg_divisor),
        .cfg_enable (cfg_enable),
        .cfg_oneshot(cfg_oneshot),
        .tick       (tick),
        .active     (active),
        .pending    (pending)
    );

    tick_scheduler #(.CHANNELS(3), .BITS(4)) dut4 (
        .in_clock   (in_clock),
        .reset_n    (reset_n),
        .cfg_valid  (cfg4_valid),
        .cfg_ready  (cfg4_ready),
        .cfg_channel(cfg4_channel),
        .cfg_divisor(cfg4_divisor),
        .cfg_enable (cfg4_enable),
        .cfg_oneshot(cfg4_oneshot),
        .tick       (tick4),
        .active     (active4),
        .pending    (pending4)
    );

    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Called at a falling edge; the request is accepted at the next rising edge
    // and the task returns at the falling edge after it (cycle k=0).
    task automatic applyStimulus(input logic [1:0] ch, input logic [7:0] d,
                                 input logic en, input logic os);
        cfg_valid   = 1'b1;
        cfg_channel = ch;
        cfg_divisor = d;
        cfg_enable  = en;
        cfg_oneshot = os;
        @(negedge in_clock);
        cfg_valid   = 1'b0;
    endtask

    task automatic applyStimulus4(input logic [1:0] ch, input logic [3:0] d,
                                  input logic en, input logic os);
        cfg4_valid   = 1'b1;
        cfg4_channel = ch;
        cfg4_divisor = d;
        cfg4_enable  = en;
        cfg4_oneshot = os;
        @(negedge in_clock);
        cfg4_valid   = 1'b0;
    endtask

    task automatic doReset();
        reset_n    = 1'b0;
        cfg_valid  = 1'b0;
        cfg4_valid = 1'b0;
        repeat (2) @(negedge in_clock);
        reset_n = 1'b1;
        @(negedge in_clock);
    endtask

    initial begin
        reset_n      = 1'b0;
        cfg_valid    = 1'b0;
        cfg_channel  = '0;
        cfg_divisor  = '0;
        cfg_enable   = 1'b0;
        cfg_oneshot  = 1'b0;
        cfg4_valid   = 1'b0;
        cfg4_channel = '0;
        cfg4_divisor = '0;
        cfg4_enable  = 1'b0;
        cfg4_oneshot = 1'b0;

        // Reset values, then a free-running channel 0 with D=3.
        doReset();
        checkOutput("rst_tick", 32'(tick), 0);
        checkOutput("rst_active", 32'(active), 0);
        checkOutput("rst_ready", 32'(cfg_ready), 1);
        checkOutput("rst_pending", 32'(pending), 0);
        applyStimulus(2'd0, 8'd3, 1'b1, 1'b0);
        checkOutput("t1_active", 32'(active), 32'h1);
        checkOutput("t1_tick0", 32'(tick), 0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge in_clock);
            checkOutput("t1_tick", 32'(tick), ((k % 4) == 3) ? 1 : 0);
        end

        // Deferred reprogram of channel 1 from D=9 to D=1.
        doReset();
        applyStimulus(2'd1, 8'd9, 1'b1, 1'b0);
        repeat (4) @(negedge in_clock);
        applyStimulus(2'd1, 8'd1, 1'b1, 1'b0);
        for (int k = 5; k <= 13; k++) begin
            checkOutput("t2_tick", 32'(tick), (k == 9 || k == 11 || k == 13) ? 32'h2 : 0);
            checkOutput("t2_pending", 32'(pending), (k <= 9) ? 1 : 0);
            checkOutput("t2_ready", 32'(cfg_ready), (k <= 9) ? 0 : 1);
            @(negedge in_clock);
        end

        // Oneshot on channel 2 with D=5.
        doReset();
        applyStimulus(2'd2, 8'd5, 1'b1, 1'b1);
        checkOutput("t3_active0", 32'(active), 32'h4);
        for (int k = 1; k <= 50; k++) begin
            @(negedge in_clock);
            checkOutput("t3_tick", 32'(tick), (k == 5) ? 32'h4 : 0);
            checkOutput("t3_active", 32'(active), (k <= 5) ? 32'h4 : 0);
        end

        // D=0 holds tick high; a request coinciding with a tick applies directly.
        doReset();
        applyStimulus(2'd0, 8'd0, 1'b1, 1'b0);
        checkOutput("t4_tick_a", 32'(tick), 1);
        @(negedge in_clock);
        checkOutput("t4_tick_b", 32'(tick), 1);
        applyStimulus(2'd0, 8'd2, 1'b1, 1'b0);
        checkOutput("t4_direct_pend", 32'(pending), 0);
        checkOutput("t4_direct_ready", 32'(cfg_ready), 1);
        checkOutput("t4_direct_tick0", 32'(tick), 0);
        @(negedge in_clock);
        checkOutput("t4_direct_tick1", 32'(tick), 0);
        @(negedge in_clock);
        checkOutput("t4_direct_tick2", 32'(tick), 1);
        applyStimulus(2'd0, 8'd0, 1'b1, 1'b0);
        checkOutput("t4_restart_tick", 32'(tick), 1);
        applyStimulus(2'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("t4_stop_tick", 32'(tick), 0);
        checkOutput("t4_stop_active", 32'(active), 0);
        checkOutput("t4_stop_pend", 32'(pending), 0);

        // Narrow instance: D=15 is a 16-cycle period; channel 3 is out of range.
        doReset();
        applyStimulus4(2'd0, 4'd15, 1'b1, 1'b0);
        checkOutput("t5_active", 32'(active4), 32'h1);
        for (int k = 1; k <= 64; k++) begin
            @(negedge in_clock);
            checkOutput("t5_tick", 32'(tick4), ((k % 16) == 15) ? 1 : 0);
        end
        applyStimulus4(2'd3, 4'd2, 1'b1, 1'b0);
        checkOutput("t5_oor_active", 32'(active4), 32'h1);
        checkOutput("t5_oor_pend", 32'(pending4), 0);
        checkOutput("t5_oor_ready", 32'(cfg4_ready), 1);

        // Asynchronous reset with a pending update outstanding on channel 3.
        doReset();
        applyStimulus(2'd3, 8'd30, 1'b1, 1'b0);
        repeat (5) @(negedge in_clock);
        applyStimulus(2'd3, 8'd20, 1'b1, 1'b0);
        checkOutput("t6_pending_set", 32'(pending), 1);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_async_tick", 32'(tick), 0);
        checkOutput("t6_async_active", 32'(active), 0);
        checkOutput("t6_async_pend", 32'(pending), 0);
        checkOutput("t6_async_ready", 32'(cfg_ready), 1);
        @(negedge in_clock);
        reset_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge in_clock);
            checkOutput("t6_quiet_tick", 32'(tick), 0);
            checkOutput("t6_quiet_ready", 32'(cfg_ready), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel clock-enable scheduler built around per-channel programmable down-counters, replacing fixed power-of-two clock division with single-cycle `tick` strobes at runtime-configurable periods. A single valid/ready configuration port shares the divider bank between channels. Reprogramming a running channel is deferred to that channel's period boundary, so no period is ever truncated. Sits between the control/register logic and the multiplier datapath stages that need slow, periodic enables.

## Interface
- `CHANNELS`, default 4: number of independent tick channels (≥1).
- `BITS`, default 8: divisor/counter width; period range 1..2^BITS cycles.
- `CW`, default `$clog2(CHANNELS)` (min 1): channel index width.

Ports:
- `in_clock`  input  1  clock. All state changes on the rising edge.
- `reset_n`  input  1  reset; asynchronous, active-low.
- `cfg_valid`  input  1  configuration request present.
- `cfg_ready`  output  1  slot free; transfer occurs when `cfg_valid && cfg_ready` at a rising edge.
- `cfg_channel`  input  CW  target channel; values ≥ CHANNELS are accepted and ignored.
- `cfg_divisor`  input  BITS  D; the period is D+1 cycles.
- `cfg_enable`  input  1  1 = run channel, 0 = stop channel.
- `cfg_oneshot`  input  1  1 = channel stops itself after its first tick.
- `tick`  output  CHANNELS  per-channel enable strobe.
- `active`  output  CHANNELS  per-channel enabled flag.
- `pending`  output  1  a deferred configuration is waiting.

## Operation
- Per-channel state: `en`, `oneshot`, `div[BITS]`, `cnt[BITS]`.
- `tick[i] = en[i] && cnt[i]==0` (combinational from registers). `active[i] = en[i]`.
- Running channel, per edge:
  - If `cnt==0`: `cnt <= div`.
  - Otherwise: `cnt <= cnt-1`.
  - If `tick[i]` and `oneshot[i]`: `en[i] <= 0`.
- Accepted request to channel c is applied directly, at the acceptance edge, if any of these hold:
  - `en[c]==0`;
  - `cfg_enable==0`;
  - `tick[c]==1` in that cycle (boundary).
- Direct apply: `en<=cfg_enable`, `div<=cfg_divisor`, `oneshot<=cfg_oneshot`, `cnt<=cfg_divisor`.
  - This replaces the normal reload and oneshot self-clear for that edge.
- Otherwise the request is stored in the single pending slot: `pending<=1`, `cfg_ready<=0`.
- Pending slot applies at the edge where its target channel's `tick` is high, with the same effect as a direct apply. At that edge `pending<=0`.
- A pending request never aborts a period in progress. A stop (`cfg_enable=0`) is always immediate and never pends.
- `cfg_ready = !pending` (registered-state only; independent of `cfg_valid`).
- Channels are fully independent: a pending update to one channel never delays ticks on others.
- Wrap: `cnt` never underflows; reload happens only at 0.
  - D = 2^BITS−1 gives a period of 2^BITS cycles.
  - D = 0 holds `tick` high every cycle while enabled.

## Timing
- Reset (async assert, sync-safe deassert is external):
  - every channel `en=0`, `oneshot=0`, `div=0`, `cnt=0`;
  - `pending=0`.
  - Outputs: `tick=0`, `active=0`, `cfg_ready=1`, `pending=0`.
- Reset mid-operation drops any pending request and all counts immediately.
- Start latency for a direct enable accepted at edge E0 with divisor D:
  - `active` high from E0.
  - First `tick` in the cycle following edge E0+D.
  - Subsequent ticks every D+1 cycles.
- Oneshot with divisor D: exactly one tick, D cycles after acceptance. `active` falls at the edge ending the tick cycle.
- Deferred reprogram: the old tick still asserts in the boundary cycle. The new period D' starts at that edge, so the next tick comes D'+1 cycles later.
- `cfg_ready` returns high in the cycle after the pending apply edge.
- Simultaneous acceptance and tick on the same channel: the request applies directly and nothing is stored.
- A request to an out-of-range channel consumes the handshake with no effect.

## Test plan
- Reset, then accept {ch0, D=3, en=1, oneshot=0} → `active[0]` rises next cycle; `tick[0]` pulses 3 cycles after acceptance, then every 4 cycles; other ticks stay 0.
- ch1 running D=9; accept {ch1, D=1} mid-period → `pending=1`, `cfg_ready=0` until ch1's tick. Spacing is 10 cycles up to the boundary, then 2; `cfg_ready=1` the cycle after.
- ch2 oneshot D=5 → a single 1-cycle `tick[2]` 5 cycles after acceptance; `active[2]` then 0; no further ticks over 50 cycles.
- ch0 running D=0 (`tick` constantly high); accept stop → `tick[0]` and `active[0]` fall the next cycle. Acceptance coinciding with a tick applies directly, with no `pending`.
- BITS=4, D=15 → period of exactly 16 cycles for 4 periods, and no underflow glitch.
- Pending update outstanding on ch3 with D=20; assert `reset_n=0` mid-period → all outputs to reset values asynchronously; after release `cfg_ready=1` and no tick is observed for 30 cycles.
